// File: rtl/alu16_pipe.sv
// alu16_pipe: two-stage pipelined HACK ALU with valid/ready handshakes.
// Define ALU16_PIPE_SKID_EN to add a one-entry skid buffer ahead of stage 1.
module alu16_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
  } beat_t;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic        f;
    logic        no;
  } s1_t;

  // encoding is {s1_v, s2_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    S2    = 2'b01,
    S1    = 2'b10,
    BOTH  = 2'b11
  } occ_t;

  occ_t  occ, occ_nx;
  logic  s1_v, s2_v;
  logic  s1_ld, s2_ld;
  logic  in_fire;
  logic  s1_nx, s2_nx;
  beat_t in_b, src;
  s1_t   s1_q;
  logic [15:0] r, res;

  assign s1_v = occ[1];
  assign s2_v = occ[0];

  assign in_b = '{x: x, y: y, zx: zx, nx: nx,
                  zy: zy, ny: ny, f: f, no: no};

  function automatic s1_t cond(input beat_t b);
    s1_t o;
    o.x1 = b.zx ? 16'h0000 : b.x;
    o.x1 = b.nx ? ~o.x1 : o.x1;
    o.y1 = b.zy ? 16'h0000 : b.y;
    o.y1 = b.ny ? ~o.y1 : o.y1;
    o.f  = b.f;
    o.no = b.no;
    return o;
  endfunction

`ifdef ALU16_PIPE_SKID_EN
  logic  sk_v;
  beat_t sk_q;
  logic  s1_can;

  assign s1_can   = !s1_v || s2_ld;
  assign in_ready = !sk_v;
  assign in_fire  = in_valid && in_ready;
  assign s1_ld    = s1_can && (sk_v || in_fire);
  assign src      = sk_v ? sk_q : in_b;

  // skid holds a beat taken while stage 1 was blocked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_v <= 1'b0;
      sk_q <= '0;
    end else begin
      if (in_fire && !s1_can) begin
        sk_v <= 1'b1;
        sk_q <= in_b;
      end else if (sk_v && s1_can) begin
        sk_v <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !s1_v || !s2_v || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_ld    = in_fire;
  assign src      = in_b;
`endif

  always_comb begin
    s2_ld  = s1_v && (!s2_v || out_ready);
    s1_nx  = s1_v;
    s2_nx  = s2_v;
    if (s1_ld)
      s1_nx = 1'b1;
    else if (s2_ld)
      s1_nx = 1'b0;
    if (s2_ld)
      s2_nx = 1'b1;
    else if (out_ready)
      s2_nx = 1'b0;
    occ_nx = occ_t'({s1_nx, s2_nx});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      occ <= EMPTY;
    else
      occ <= occ_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      s1_q <= '0;
    else if (s1_ld)
      s1_q <= cond(src);
  end

  assign r   = s1_q.f ? (s1_q.x1 + s1_q.y1)
                      : (s1_q.x1 & s1_q.y1);
  assign res = s1_q.no ? ~r : r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= 16'h0000;
      zr  <= 1'b0;
      ng  <= 1'b0;
    end else if (s2_ld) begin
      out <= res;
      zr  <= (res == 16'h0000);
      ng  <= res[15];
    end
  end

  assign out_valid = s2_v;

endmodule

// File: tb/tb_alu16_pipe.sv
// tb_alu16_pipe: directed vector table plus handshake corner sequences.
// Honours ALU16_PIPE_SKID_EN for the expected pipeline capacity.
module tb_alu16_pipe;

`ifdef ALU16_PIPE_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu16_pipe dut (
    .clk(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] o;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic set_ctrl(input logic [5:0] c);
    {zx, nx, zy, ny, f, no} = c;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    x = v.x;
    y = v.y;
    set_ctrl(v.c);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", k), 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    set_ctrl(6'($urandom));
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk($sformatf("v%0d_latency", k), 16'(lat), 16'd2);
    chk($sformatf("v%0d_out", k), out, v.o);
    chk($sformatf("v%0d_zr", k), 16'(zr), 16'(v.z));
    chk($sformatf("v%0d_ng", k), 16'(ng), 16'(v.n));
    step();
    chk($sformatf("v%0d_drain", k), 16'(out_valid), 16'd0);
  endtask

  initial begin
    int acc, dlv, held, first_t, got, gaps;
    bit seen;

    vt[0] = '{16'h00F0, 16'h0FF0, 6'b000000, 16'h00F0, 1'b0, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
    vt[4] = '{16'hAAAA, 16'h5555, 6'b101010, 16'h0000, 1'b1, 1'b0};
    vt[5] = '{16'h0F0F, 16'hF0F0, 6'b111111, 16'h0001, 1'b0, 1'b0};
    vt[6] = '{16'h1234, 16'h00FF, 6'b000001, 16'hFFCB, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    set_ctrl(6'b0);
    step();
    step();
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out", out, 16'h0000);
    chk("rst_zr", 16'(zr), 16'd0);
    chk("rst_ng", 16'(ng), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_vec(vt[i], i);

    acc = 0;
    dlv = 0;
    held = -1;
    set_ctrl(6'b000010);
    y = 16'h0000;
    for (int t = 0; t < 40 && dlv < 5; t++) begin
      in_valid  = (acc < 5);
      x         = 16'(acc + 1);
      out_ready = !(t >= 2 && t <= 5);
      #1;
      if (!in_ready && held < 0)
        held = acc - dlv;
      if (out_valid && out_ready) begin
        chk("bp_order", out, 16'(dlv + 1));
        dlv++;
      end
      if (in_valid && in_ready)
        acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_delivered", 16'(dlv), 16'd5);
    chk("bp_held_at_stall", 16'(held), 16'(CAP));
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("bp_no_dup", 16'(out_valid), 16'd0);
      step();
    end

    in_valid = 1'b1;
    out_ready = 1'b0;
    x = 16'h0009;
    y = 16'h0003;
    set_ctrl(6'b000010);
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("mid_rst_no_stale", 16'(out_valid), 16'd0);
    end

    acc = 0;
    got = 0;
    gaps = 0;
    first_t = -1;
    seen = 0;
    out_ready = 1'b1;
    y = 16'h0100;
    set_ctrl(6'b000010);
    for (int t = 0; t < 40 && got < 16; t++) begin
      in_valid = (acc < 16);
      x = 16'(acc + 1);
      #1;
      if (out_valid) begin
        if (first_t < 0)
          first_t = t;
        else if (!seen)
          gaps++;
        chk("tp_value", out, 16'(16'h0100 + got + 1));
        got++;
        seen = 1;
      end else begin
        seen = 0;
      end
      if (in_valid && in_ready)
        acc++;
      step();
    end
    in_valid = 1'b0;
    chk("tp_first_cycle", 16'(first_t), 16'd2);
    chk("tp_count", 16'(got), 16'd16);
    chk("tp_gaps", 16'(gaps), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
